// File: rtl/counter_bank_if.sv
// rtl/counter_bank_if.sv - control and count bus between fabric control logic and counter_bank
interface counter_bank_if #(
    parameter int CH = 4,
    parameter int W  = 8
);
    logic              clr;
    logic [CH-1:0]     ch_clr;
    logic [CH-1:0]     ld;
    logic [CH*W-1:0]   ld_val;
    logic [CH-1:0]     en;
    logic [CH-1:0]     dn;
    logic [CH-1:0]     ovf_clr;
    logic [CH*W-1:0]   dout;
    logic [CH*W-1:0]   dout_comb;
    logic [CH-1:0]     tc;
    logic [CH-1:0]     ovf;

    // Control side: issues strobes and observes counts/flags.
    modport master (
        output clr, ch_clr, ld, ld_val, en, dn, ovf_clr,
        input  dout, dout_comb, tc, ovf
    );

    // Counter side: consumes strobes and presents counts/flags.
    modport slave (
        input  clr, ch_clr, ld, ld_val, en, dn, ovf_clr,
        output dout, dout_comb, tc, ovf
    );
endinterface

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of CH independent up/down counters with wrap/saturate, tc pulses and sticky overflow
module counter_bank #(
    parameter int CH  = 4,
    parameter int W   = 8,
    parameter int MAX = 255,
    parameter int SAT = 0
) (
    input logic          clk,
    input logic          rst,
    counter_bank_if.slave bus
);
    localparam logic [W-1:0] MAX_V = W'(MAX);
    // Clamping is only reachable when MAX leaves part of the W-bit code space unused.
    localparam bit CLAMP = (MAX < ((2 ** W) - 1));
    localparam bit SAT_B = (SAT != 0);

    logic [CH*W-1:0] cnt_q;
    logic [CH*W-1:0] cnt_d;
    logic [CH-1:0]   tc_q;
    logic [CH-1:0]   tc_d;
    logic [CH-1:0]   ovf_q;
    logic [CH-1:0]   ovf_d;
    logic [W-1:0]    cur;
    logic [W-1:0]    ldv;
    logic            at_bound;

    // Next-state per channel: clear > load > count > hold; boundary steps raise tc and ovf.
    always_comb begin
        cnt_d    = cnt_q;
        tc_d     = '0;
        ovf_d    = ovf_q;
        cur      = '0;
        ldv      = '0;
        at_bound = 1'b0;
        for (int i = 0; i < CH; i++) begin
            cur      = cnt_q[i*W +: W];
            ldv      = bus.ld_val[i*W +: W];
            at_bound = 1'b0;
            if (bus.clr || bus.ch_clr[i]) begin
                cnt_d[i*W +: W] = '0;
            end else if (bus.ld[i]) begin
                cnt_d[i*W +: W] = (CLAMP && (ldv > MAX_V)) ? MAX_V : ldv;
            end else if (bus.en[i]) begin
                if (bus.dn[i]) begin
                    if (cur == '0) begin
                        at_bound        = 1'b1;
                        cnt_d[i*W +: W] = SAT_B ? '0 : MAX_V;
                    end else begin
                        cnt_d[i*W +: W] = cur - 1'b1;
                    end
                end else begin
                    if (cur == MAX_V) begin
                        at_bound        = 1'b1;
                        cnt_d[i*W +: W] = SAT_B ? MAX_V : '0;
                    end else begin
                        cnt_d[i*W +: W] = cur + 1'b1;
                    end
                end
            end
            tc_d[i]  = at_bound;
            // A boundary step in the same cycle wins over any overflow clear.
            ovf_d[i] = at_bound | (ovf_q[i] & ~bus.ovf_clr[i] & ~bus.clr);
        end
    end

    // Register count, terminal-count pulse and sticky overflow; reset drops everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.dout      = cnt_q;
    assign bus.dout_comb = rst ? '0 : cnt_d;
    assign bus.tc        = tc_q;
    assign bus.ovf       = ovf_q;
endmodule
